// File: rtl/car_motion_scheduler_pkg.sv
// Shared game parameters: playfield geometry and per-car motion tables.
// The VGA display block imports the same package so both agree on car placement.
package car_motion_scheduler_pkg;

    localparam int NUM_CARS_DEF = 10;
    localparam int H_WRAP_DEF   = 640;
    localparam int CAR_SIZE     = 32;
    localparam int TBL_N        = 10;

    localparam logic [9:0] LANE_Y [TBL_N] = '{
        10'd40,  10'd80,  10'd120, 10'd160, 10'd200,
        10'd240, 10'd280, 10'd320, 10'd360, 10'd400
    };

    localparam logic [9:0] START_X [TBL_N] = '{
        10'd636, 10'd631, 10'd3,   10'd5,   10'd100,
        10'd300, 10'd0,   10'd639, 10'd320, 10'd500
    };

    // 0 = moving right, 1 = moving left
    localparam logic CAR_DIR [TBL_N] = '{
        1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b1, 1'b0, 1'b1, 1'b0, 1'b1
    };

    localparam logic [3:0] CAR_SPEED [TBL_N] = '{
        4'd8, 4'd8, 4'd5, 4'd5, 4'd2,
        4'd3, 4'd15, 4'd1, 4'd4, 4'd7
    };

    localparam logic [2:0] CAR_PERIOD [TBL_N] = '{
        3'd1, 3'd1, 3'd1, 3'd1, 3'd3,
        3'd2, 3'd7, 3'd1, 3'd5, 3'd4
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/car_step.sv
// One horizontal step of a car with wraparound inside [0, H_WRAP-1].
module car_step #(
    parameter int H_WRAP = 640
) (
    input  logic [9:0] x,
    input  logic       dir,
    input  logic [3:0] speed,
    output logic [9:0] nx
);

    logic [10:0] sum_s;

    // Right-step sum kept at 11 bits so the wrap compare sees the carry.
    assign sum_s = {1'b0, x} + {7'b0, speed};

    // Select right or left step, wrapping around the playfield edge.
    always_comb begin
        nx = x;
        if (dir == 1'b0) begin
            if (sum_s >= 11'(H_WRAP)) begin
                nx = 10'(sum_s - 11'(H_WRAP));
            end else begin
                nx = sum_s[9:0];
            end
        end else begin
            if (x < {6'b0, speed}) begin
                nx = 10'({1'b0, x} + 11'(H_WRAP) - {7'b0, speed});
            end else begin
                nx = x - {6'b0, speed};
            end
        end
    end

endmodule

// File: rtl/car_motion_scheduler.sv
// Per-frame car motion sequencer: on each frame tick it sweeps all cars, one per
// cycle, through a shared step unit, advancing each car when its frame divider expires.
module car_motion_scheduler
    import car_motion_scheduler_pkg::*;
#(
    parameter int NUM_CARS = NUM_CARS_DEF,
    parameter int H_WRAP   = H_WRAP_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic                    run,
    output logic [10*NUM_CARS-1:0]  car_x_bus,
    output logic [10*NUM_CARS-1:0]  car_y_bus,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    state_e           state_r;
    state_e           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [9:0]       x_r   [NUM_CARS];
    logic [2:0]       div_r [NUM_CARS];
    logic             busy_r;
    logic             sweep_done_r;
    logic             overrun_r;
    logic             last_s;
    logic [9:0]       nx_s;

    assign last_s = (idx_r == IDX_W'(NUM_CARS - 1));

    car_step #(.H_WRAP(H_WRAP)) u_car_step (
        .x     (x_r[idx_r]),
        .dir   (CAR_DIR[idx_r]),
        .speed (CAR_SPEED[idx_r]),
        .nx    (nx_s)
    );

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_tick && run) begin
                    state_s = SWEEP;
                end else begin
                    state_s = IDLE;
                end
            end
            SWEEP: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SWEEP;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, car index and status flags; busy/sweep_done mirror the state registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s == SWEEP);
            sweep_done_r <= (state_s == DONE);
            if (state_r == SWEEP && !last_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= '0;
            end
            // A tick that lands outside IDLE is dropped; set beats clear.
            if (frame_tick && state_r != IDLE) begin
                overrun_r <= 1'b1;
            end else if (overrun_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Car position and divider arrays; only the car under service changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                x_r[i]   <= START_X[i];
                div_r[i] <= CAR_PERIOD[i];
            end
        end else if (state_r == SWEEP) begin
            if (div_r[idx_r] == 3'd1) begin
                div_r[idx_r] <= CAR_PERIOD[idx_r];
                x_r[idx_r]   <= nx_s;
            end else begin
                div_r[idx_r] <= div_r[idx_r] - 3'd1;
            end
        end else begin
            for (int i = 0; i < NUM_CARS; i++) begin
                x_r[i]   <= x_r[i];
                div_r[i] <= div_r[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_bus
        assign car_x_bus[10*g +: 10] = x_r[g];
        assign car_y_bus[10*g +: 10] = LANE_Y[g];
    end

    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_car_motion_scheduler.sv
// Scoreboard bench for car_motion_scheduler: stimulus queues expected car positions
// and sweep length; a monitor checks them on every sweep_done pulse.
module tb_car_motion_scheduler;

    localparam int N = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_tick = 1'b0;
    logic           run = 1'b0;
    logic           overrun_clr = 1'b0;
    logic [10*N-1:0] car_x_bus;
    logic [10*N-1:0] car_y_bus;
    logic           busy;
    logic           sweep_done;
    logic           overrun;

    car_motion_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .run         (run),
        .car_x_bus   (car_x_bus),
        .car_y_bus   (car_y_bus),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Hand-written copy of the game tables
    int st_x [N] = '{636, 631, 3, 5, 100, 300, 0, 639, 320, 500};
    int dirs [N] = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 1};
    int spd  [N] = '{8, 8, 5, 5, 2, 3, 15, 1, 4, 7};
    int per  [N] = '{1, 1, 1, 1, 3, 2, 7, 1, 5, 4};
    int c4_exp [10] = '{0, 100, 100, 102, 102, 102, 104, 104, 104, 106};

    int mx [N];
    int mdiv [N];

    typedef struct {
        logic [10*N-1:0] xs;
        int              blen;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    function automatic int ref_step(int x, int d, int s);
        if (d == 0) return (x + s) % 640;
        else        return (x - s + 640) % 640;
    endfunction

    function automatic logic [10*N-1:0] pack_model();
        logic [10*N-1:0] v;
        for (int i = 0; i < N; i++) v[10*i +: 10] = mx[i][9:0];
        return v;
    endfunction

    function automatic int carx(int i);
        return int'(car_x_bus[10*i +: 10]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]   = st_x[i];
            mdiv[i] = per[i];
        end
    endtask

    task automatic model_tick();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (mdiv[i] == 1) begin
                mdiv[i] = per[i];
                mx[i]   = ref_step(mx[i], dirs[i], spd[i]);
            end else begin
                mdiv[i] = mdiv[i] - 1;
            end
        end
        e.xs   = pack_model();
        e.blen = N;
        q.push_back(e);
    endtask

    task automatic do_tick();
        @(posedge clk) #1 frame_tick = 1'b1;
        @(posedge clk) #1 frame_tick = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (done_cnt == start && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == start) begin
            tests++;
            fails++;
            $display("FAIL sweep_timeout: got no sweep_done within %0d cycles", n);
        end
    endtask

    task automatic sweep();
        int s = done_cnt;
        model_tick();
        do_tick();
        wait_done(s);
    endtask

    // Monitor: measures busy length and checks positions on each sweep_done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (sweep_done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sweep_unexpected: got sweep_done with no sweep pending");
                end else begin
                    e = q.pop_front();
                    tests++;
                    if (car_x_bus !== e.xs) begin
                        fails++;
                        $display("FAIL sweep_x: got %h expected %h", car_x_bus, e.xs);
                    end
                    check("busy_len", busy_cnt, e.blen);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int s;
        run = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset_car0_x", carx(0), 636);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_sweep_done", int'(sweep_done), 0);
        check("lane_y_car9", int'(car_y_bus[99:90]), 400);
        check("lane_y_car0", int'(car_y_bus[9:0]), 40);

        // First sweep: wrap cases on cars 0..3, divider start on car 4
        sweep();
        @(negedge clk);
        check("right_wrap_636", carx(0), 4);
        check("right_edge_631", carx(1), 639);
        check("left_wrap_3", carx(2), 638);
        check("left_zero_5", carx(3), 0);
        check("div_tick1", carx(4), c4_exp[1]);

        for (int t = 2; t <= 9; t++) begin
            sweep();
            @(negedge clk);
            check($sformatf("div_tick%0d", t), carx(4), c4_exp[t]);
        end

        // Paused: ticks ignored, nothing moves
        @(posedge clk) #1 run = 1'b0;
        repeat (4) begin
            do_tick();
            repeat (12) @(posedge clk);
        end
        @(negedge clk);
        tests++;
        if (car_x_bus !== pack_model()) begin
            fails++;
            $display("FAIL paused_x: got %h expected %h", car_x_bus, pack_model());
        end
        check("paused_car4", carx(4), 106);
        check("paused_overrun", int'(overrun), 0);
        @(posedge clk) #1 run = 1'b1;

        // Run drops at sweep cycle 2, extra tick at cycle 4: full sweep, overrun set
        s = done_cnt;
        model_tick();
        @(posedge clk) #1 frame_tick = 1'b1;
        @(posedge clk) #1 frame_tick = 1'b0;
        @(posedge clk) #1 run = 1'b0;
        repeat (2) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk) #1 frame_tick = 1'b0;
        wait_done(s);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("overrun_set", int'(overrun), 1);
        @(posedge clk) #1 overrun_clr = 1'b1;
        @(posedge clk) #1 overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_clr", int'(overrun), 0);
        @(posedge clk) #1 run = 1'b1;

        // Reset at sweep cycle 5 discards the partial sweep
        @(posedge clk) #1 frame_tick = 1'b1;
        @(posedge clk) #1 frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk) #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        tests++;
        if (car_x_bus !== pack_model()) begin
            fails++;
            $display("FAIL midreset_x: got %h expected %h", car_x_bus, pack_model());
        end
        check("midreset_busy", int'(busy), 0);
        repeat (15) @(posedge clk);

        sweep();
        @(negedge clk);
        check("post_reset_car0", carx(0), 4);
        check("post_reset_car4", carx(4), 100);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/car_motion_scheduler.md
CAR_MOTION_SCHEDULER -- requirements
Module: car_motion_scheduler

Interface
REQ-001 SHALL have parameter NUM_CARS, default 10, the number of cars sequenced.
REQ-002 SHALL have parameter H_WRAP, default 640, the horizontal wrap width in pixels.
REQ-003 SHALL have port clk, input, 1, the single clock (pixel clock domain); all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 SHALL have port frame_tick, input, 1, a one-cycle pulse at the start of vertical blanking.
REQ-006 SHALL have port run, input, 1; when 1, motion is enabled, and when 0 the game is paused.
REQ-007 SHALL have port car_x_bus, output, 10*NUM_CARS; car i x is held in bits [10*i+9:10*i].
REQ-008 SHALL have port car_y_bus, output, 10*NUM_CARS; car i y is held in bits [10*i+9:10*i].
REQ-009 SHALL have port busy, output, 1, high while the update sweep is in progress.
REQ-010 SHALL have port sweep_done, output, 1, a one-cycle pulse at the end of each sweep.
REQ-011 SHALL have port overrun, output, 1, sticky; it is set when a frame_tick arrives while busy.
REQ-012 SHALL have port overrun_clr, input, 1, which clears overrun.

Function
REQ-013 SHALL take per-car constants from tables indexed 0..NUM_CARS-1: lane y (10b), start x (10b), dir (0=right, 1=left), speed (4b, pixels/step, 1..15), period (3b, frames per step, 1..7).
REQ-014 SHALL drive car_y_bus constantly from the lane-y table; y never changes.
REQ-015 SHALL implement an FSM with states IDLE, SWEEP, and DONE.
REQ-016 SHALL move IDLE->SWEEP on frame_tick=1 && run=1, loading idx=0 and asserting busy the next cycle.
REQ-017 SHALL service car idx in SWEEP one car per cycle: decrement its frame divider; if the divider is 1, reload it with period and apply one step to x, otherwise leave x unchanged.
REQ-018 SHALL increment idx each SWEEP cycle and go to DONE after idx=NUM_CARS-1; a sweep therefore lasts exactly NUM_CARS cycles.
REQ-019 SHALL pulse sweep_done for one cycle in DONE, then return to IDLE; busy SHALL be low in DONE and IDLE.
REQ-020 SHALL step right as nx = x+speed, and if nx >= H_WRAP, nx = x+speed-H_WRAP (11-bit intermediate, no truncation before compare).
REQ-021 SHALL step left as: if x < speed, nx = x+H_WRAP-speed, else nx = x-speed.
REQ-022 SHALL keep x in [0, H_WRAP-1] at all times.
REQ-023 SHALL ignore frame_tick while run=0 (dividers and x frozen); if run falls mid-sweep, the sweep completes.
REQ-024 SHALL ignore a frame_tick received in SWEEP or DONE and set overrun; if overrun_clr coincides with a new overrun event, set wins.
REQ-025 SHALL update each car_x_bus field only in its service cycle; the register is visible the cycle after.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge: set state=IDLE, idx=0, busy=0, sweep_done=0, overrun=0, every x to its start x, and every divider to its period.
REQ-027 SHALL, on reset mid-sweep, abort the sweep with no partial updates retained.

Structure
REQ-028 SHALL keep NUM_CARS, H_WRAP, CAR_SIZE (32), and the lane-y/start-x/dir/speed/period tables in the shared game parameter include, also used by the VGA display block.
REQ-029 SHALL contain one combinational sub-module, car_step (inputs x, dir, speed; output nx), implementing REQ-020/REQ-021.
REQ-030 SHALL keep dividers and x in register arrays, using a single car_step instance muxed by idx.

Verification
REQ-031 SHALL check reset: after rst_n low then high, car0 x equals its start x, busy=0, and overrun=0.
REQ-032 SHALL check the sweep: one frame_tick with run=1 gives busy high for exactly 10 cycles, then a sweep_done pulse 1 cycle later.
REQ-033 SHALL check right wrap: with car dir=0, speed=8, period=1, and x=636, the next sweep gives x=4; with x=631 it gives 639.
REQ-034 SHALL check left wrap: with car dir=1, speed=5, period=1, and x=3, the next sweep gives x=638; with x=5 it gives 0.
REQ-035 SHALL check the divider: with period=3, x changes only on the 3rd, 6th, and 9th frame_tick, and run=0 for 4 ticks changes nothing.
REQ-036 SHALL check overrun and reset mid-sweep: a second frame_tick at sweep cycle 4 sets overrun and leaves the sweep length unchanged; overrun_clr clears it; rst_n low at sweep cycle 5 restores every x to its start x.
